// File: rtl/sum8_pkg.sv
// sum8_pkg: shared constants and types for the multi-byte add/subtract
// sequencer built around the sum8r ripple adder.
//   BYTE_W  - width of one operand/result byte
//   state_e - sequencer state (S_IDLE waits for byte 0, S_RUN for bytes 1..N-1)
//   clog2() - byte-index width for a given byte count, never less than 1
package sum8_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Index width for n bytes; a single-byte build still needs a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sum8r.sv
// sum8r: 8-bit ripple-carry adder, purely combinational.
// Ports:
//   a, b : addends
//   ci   : carry-in
//   s    : sum (a + b + ci) mod 256
//   co   : carry-out of bit 7
module sum8r
    import sum8_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/sum8_chain.sv
// sum8_chain: multi-byte add/subtract sequencer around one sum8r adder.
// Operands arrive least-significant byte first as byte pairs; the carry of
// each byte is kept in c_q and fed into the next byte. Results leave through
// a single output register with a last-byte marker plus word carry/borrow-out
// and signed overflow on the last byte.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake for a_byte, b_byte, ci, sub
//   a_byte, b_byte       : operand bytes, LSB first
//   ci                   : carry-in (add) / borrow-in (sub), byte 0 only
//   sub                  : 1 = A - B, 0 = A + B, byte 0 only, held for the word
//   out_valid / out_ready: output handshake for res_byte, out_last, co, ovf
//   res_byte             : result byte
//   out_last             : res_byte is the most-significant byte
//   co, ovf              : carry/borrow-out and overflow, nonzero only with out_last
//   dbg_state            : current sequencer state (S_IDLE / S_RUN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The producer holds its data stable while valid && !ready. in_ready is
// (!out_valid || out_ready) gated by rst_n, so a new byte is taken only when
// the output register is empty or being emptied in the same cycle.
module sum8_chain
    import sum8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] a_byte,
    input  logic [BYTE_W-1:0] b_byte,
    input  logic              ci,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] res_byte,
    output logic              out_last,
    output logic              co,
    output logic              ovf,
    output logic [0:0]        dbg_state
);

    localparam int                IDX_W    = clog2(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            state;
    logic [IDX_W-1:0]  idx;
    logic              c_q;
    logic              sub_q;

    logic              accept;
    logic              consume;
    logic              first;
    logic              is_last;
    logic              s_eff;
    logic [BYTE_W-1:0] add_b;
    logic              add_ci;
    logic [BYTE_W-1:0] add_s;
    logic              add_co;
    logic              ovf_w;

    assign in_ready  = rst_n && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign dbg_state = state;

    // Byte 0 takes its mode and carry from the pins; later bytes use the
    // latched mode and the carry left by the previous byte.
    assign first   = (state == S_IDLE);
    assign is_last = (idx == LAST_IDX);
    assign s_eff   = first ? sub : sub_q;

    // Subtraction is A + ~B + 1; the borrow-in is folded into the carry-in
    // by inverting it, so carry-out 1 means "no borrow".
    assign add_b  = b_byte ^ {BYTE_W{s_eff}};
    assign add_ci = first ? (ci ^ s_eff) : c_q;

    sum8r u_add (
        .a  (a_byte),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    // Signed overflow of the whole word: addends (after inversion) agree in
    // sign but the top result bit does not.
    assign ovf_w = (a_byte[BYTE_W-1] == add_b[BYTE_W-1]) &&
                   (add_s[BYTE_W-1] != a_byte[BYTE_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            c_q       <= 1'b0;
            sub_q     <= 1'b0;
            out_valid <= 1'b0;
            res_byte  <= '0;
            out_last  <= 1'b0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                res_byte  <= add_s;
                out_last  <= is_last;
                co        <= is_last ? (add_co ^ s_eff) : 1'b0;
                ovf       <= is_last ? ovf_w : 1'b0;
                if (first) begin
                    sub_q <= sub;
                end
                if (is_last) begin
                    // Word complete: the next byte starts a fresh word.
                    state <= S_IDLE;
                    idx   <= '0;
                    c_q   <= 1'b0;
                end else begin
                    state <= S_RUN;
                    idx   <= idx + 1'b1;
                    c_q   <= add_co;
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum8_chain.sv
module tb_sum8_chain;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (NBYTES=4) ----------------
    logic       in_valid, in_ready, ci, sub, out_valid, out_ready, out_last, co, ovf;
    logic [7:0] a_byte, b_byte, res_byte;
    logic [0:0] dbg_state;

    sum8_chain #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_byte(a_byte), .b_byte(b_byte), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .res_byte(res_byte),
        .out_last(out_last), .co(co), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- DUT (NBYTES=1) ----------------
    logic       in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, out_last1, co1, ovf1;
    logic [7:0] a1, b1, res1;
    logic [0:0] dbg_state1;

    sum8_chain #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_byte(a1), .b_byte(b1), .ci(ci1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .res_byte(res1),
        .out_last(out_last1), .co(co1), .ovf(ovf1), .dbg_state(dbg_state1)
    );

    int total = 0;
    int bad   = 0;
    logic rand_bp = 1'b0;

    // Scoreboard entries: {last, co, ovf, byte}
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Whole-word arithmetic; returns {co, ovf, res}.
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
        logic [32:0] full;
        logic [31:0] r;
        logic        v;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b} + 33'(c);
            r    = full[31:0];
            v    = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - 33'(c);
            r    = full[31:0];
            v    = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {full[32], v, r};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic s);
        int av, bv, full;
        logic [7:0] r;
        logic       v;
        av = a; bv = b;
        full = s ? (av - bv - c) : (av + bv + c);
        r = full[7:0];
        v = s ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
        return {(full < 0) || (full > 255), v, r};
    endfunction

    task automatic push_word(input logic [31:0] r, input logic c, input logic v);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({(i == 3), (i == 3) ? c : 1'b0, (i == 3) ? v : 1'b0, r[8*i +: 8]});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {21'd0, out_last, co, ovf, res_byte}, 32'h7FF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", {21'd0, out_last, co, ovf, res_byte}, {21'd0, e});
                end
            end
        end
    end

    // Random output backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_byte(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        logic acc;
        int   n;
        in_valid = 1'b1; a_byte = a; b_byte = b; ci = c; sub = s;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        else      check("valid_after_accept", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic c,
                             input logic s, input logic gap);
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            // ci/sub on bytes 1..3 must be ignored, so drive noise there.
            drive_byte(a[8*i +: 8], b[8*i +: 8],
                       (i == 0) ? c : 1'($urandom_range(0, 1)),
                       (i == 0) ? s : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic        gap;
        logic [31:0] res;
        logic        eco;
        logic        eovf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [33:0] m;
        logic [9:0]  m8;
        logic [31:0] ra, rb;
        logic        rc, rs;

        vecs[0] = '{32'h00000005, 32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h0000000F, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h00000021, 32'h00000014, 1'b0, 1'b1, 1'b0, 32'h0000000D, 1'b0, 1'b0};
        vecs[4] = '{32'h00000014, 32'h00000021, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF3, 1'b1, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[8] = '{32'h00000005, 32'h0000000A, 1'b0, 1'b0, 1'b1, 32'h0000000F, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a_byte = '0; b_byte = '0; ci = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {26'd0, out_valid, out_last, co, ovf, dbg_state, 1'b0}, 32'd0);
        check("rst_res", {24'd0, res_byte}, 32'd0);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_state", {31'd0, dbg_state}, 32'd0);

        // Table-driven words
        for (int i = 0; i < 9; i++) begin
            push_word(vecs[i].res, vecs[i].eco, vecs[i].eovf);
            send_word(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].gap);
        end
        wait_drain();

        // Backpressure: hold byte 1 (0x1F) for 3 cycles
        m = model32(32'h0A141E28, 32'h01010101, 1'b0, 1'b0);
        push_word(m[31:0], m[33], m[32]);
        drive_byte(8'h28, 8'h01, 1'b0, 1'b0);
        drive_byte(8'h1E, 8'h01, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; a_byte = 8'h14; b_byte = 8'h01;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {23'd0, out_valid, res_byte}, {23'd0, 1'b1, 8'h1F});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drive_byte(8'h14, 8'h01, 1'b0, 1'b0);
        drive_byte(8'h0A, 8'h01, 1'b0, 1'b0);
        wait_drain();

        // Mid-word reset after byte 1
        exp_q.push_back({3'b000, 8'hFE});
        exp_q.push_back({3'b000, 8'hFF});
        drive_byte(8'hFF, 8'hFF, 1'b0, 1'b0);
        drive_byte(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("run_state", {31'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_outputs", {27'd0, out_valid, out_last, co, ovf, dbg_state}, 32'd0);
        check("midrst_res", {24'd0, res_byte}, 32'd0);
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_queue", exp_q.size(), 32'd0);
        push_word(32'h00000000, 1'b0, 1'b0);
        send_word(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Randomized words with random backpressure and gaps
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            if (i % 8 == 0) ra = 32'hFFFFFFFF;
            m = model32(ra, rb, rc, rs);
            push_word(m[31:0], m[33], m[32]);
            send_word(ra, rb, rc, rs, 1'((i % 3) == 0));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // NBYTES=1 build: back-to-back words at one per cycle
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin a1 = 8'hF0; b1 = 8'h20; ci1 = 1'b1; sub1 = 1'b0; end
            else begin
                a1 = 8'($urandom); b1 = 8'($urandom);
                ci1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
            end
            in_valid1 = 1'b1;
            m8 = model8(a1, b1, ci1, sub1);
            @(negedge clk);
            check("n1_in_ready", {31'd0, in_ready1}, 32'd1);
            @(posedge clk); #1;
            check("n1_out", {19'd0, out_valid1, out_last1, dbg_state1, co1, ovf1, res1},
                  {19'd0, 1'b1, 1'b1, 1'b0, m8[9], m8[8], m8[7:0]});
        end
        in_valid1 = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sum8_chain.md
# sum8_chain

Multi-byte add/subtract sequencer built around the existing `sum8r` 8-bit ripple adder. It accepts operands least-significant byte first as a stream of byte pairs, carries each byte's carry into the next byte, and emits registered result bytes with a last-byte marker, carry/borrow-out and signed overflow. It sits directly upstream and downstream of `sum8r`: it drives the adder's operands and carry-in, and it registers the adder's sum and carry.

## Interface
- `NBYTES`, 4, bytes per operand; legal range 1..16.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: byte pair on `a_byte`/`b_byte` is valid.
- `in_ready` output 1: stage can accept a byte pair this cycle.
- `a_byte` input 8: operand A byte, least-significant byte first.
- `b_byte` input 8: operand B byte.
- `ci` input 1: carry-in (add) or borrow-in (sub); sampled only on byte 0.
- `sub` input 1: 1 = A − B, 0 = A + B; sampled only on byte 0 and held for the word.
- `out_valid` output 1: `res_byte` is valid.
- `out_ready` input 1: consumer accepts `res_byte`.
- `res_byte` output 8: result byte.
- `out_last` output 1: `res_byte` is the most-significant byte of the word.
- `co` output 1: carry-out (add) or borrow-out (sub); meaningful only while `out_last`=1, otherwise 0.
- `ovf` output 1: two's-complement overflow of the whole word; meaningful only while `out_last`=1, otherwise 0.

## Operation
- Transfers occur on `in_valid && in_ready` (accept) and on `out_valid && out_ready` (consume).
- `in_ready = rst_n && (!out_valid || out_ready)`. This is a single output register with no skid buffer.
- States:
  - IDLE: byte index 0, waiting for the first byte. On accept, latch `sub` into `sub_q`. Go to RUN if `NBYTES`>1; otherwise stay in IDLE.
  - RUN: byte index 1..NBYTES-1. Accepting byte `NBYTES-1` returns the block to IDLE.
- Operands presented to `sum8r`:
  - A = `a_byte`.
  - B = `b_byte ^ {8{s}}`, where s is `sub` on byte 0 and `sub_q` afterwards.
  - Carry-in on byte 0 = `ci ^ s`. On later bytes it is the registered internal carry `c_q`.
- On every accept: `c_q` ← adder Co; `res_byte` ← adder S; `out_last` ← (index == NBYTES-1).
- On the last byte:
  - `co` ← Co ^ s.
  - `ovf` ← (A[7] == B'[7]) && (S[7] != A[7]), where B' is the inverted-or-not B byte.
- On the last byte, `c_q` clears after use.
- Result: the emitted bytes equal (A + B + ci) mod 2^(8·NBYTES) when sub=0, and (A − B − ci) mod 2^(8·NBYTES) when sub=1.
- `in_valid` may drop between bytes of a word. The state, index and `c_q` hold until the next accept.

## Timing
- Latency: a byte accepted at edge k is presented with `out_valid`=1 from edge k.
- Throughput: 1 byte/cycle when `out_ready` is held high.
- Output hold: `res_byte`, `out_last`, `co` and `ovf` hold while `out_valid && !out_ready`.
- Simultaneous consume and accept in one cycle: the output register reloads and `out_valid` stays 1.
- Consume with no accept: `out_valid` ← 0.
- Reset (`rst_n`=0 at an edge), effective mid-word too; the partial word is discarded:
  - State ← IDLE, index ← 0, `c_q` ← 0, `sub_q` ← 0.
  - `out_valid`, `out_last`, `co`, `ovf` ← 0; `res_byte` ← 8'h00.
  - `in_ready` is 0 while `rst_n`=0.
- `NBYTES`=1: every byte is last; the state never leaves IDLE.

## Structure
- Package `sum8_pkg`:
  - `BYTE_W`=8.
  - State enum `{S_IDLE, S_RUN}`.
  - Index width function `clog2(NBYTES)`, minimum 1.
- Sub-module: one `sum8r` instance (A, B, Ci, S, Co) does all the arithmetic. The block contains no other adders.

## Test plan
- Add, NBYTES=4, `out_ready`=1:
  - A=0x00000005, B=0x0000000A, ci=0 → bytes 0F,00,00,00; `out_last` on byte 3; co=0, ovf=0.
  - Each byte is valid one edge after it is accepted.
- Carry chain, NBYTES=4:
  - A=0xFFFFFFFF, B=0x00000001, ci=0 → 00,00,00,00; co=1, ovf=0.
  - A=0x7FFFFFFF, B=0x00000001 → 00,00,00,80; co=0, ovf=1.
- Subtract, NBYTES=4:
  - A=0x00000021, B=0x00000014, sub=1, ci=0 → 0D,00,00,00; co=0.
  - A=0x00000014, B=0x00000021 → F3,FF,FF,FF; co=1 (borrow).
- Backpressure, add A=0x0A141E28, B=0x01010101:
  - Drop `out_ready` for 3 cycles while byte 1 (0x1F) is pending.
  - `in_ready`=0 and `res_byte`=0x1F hold for those cycles.
  - Final sequence 29,1F,15,0B with no loss or duplication.
- Input gaps and reset:
  - Insert `in_valid`=0 gaps between bytes → same result as the gap-free run.
  - Assert `rst_n`=0 after byte 1 of a word → all outputs zero the next cycle.
  - A fresh word after reset uses `ci`, not the stale `c_q`.
- NBYTES=1 build: A=0xF0, B=0x20, ci=1 → res=0x11, out_last=1, co=1, ovf=0, with back-to-back words at 1/cycle.
